// File: rtl/mem_io_responder_if.sv
// CPU memory bus between the CPU (master) and the RAM/IO responder (slave).
// Carries a byte address, write strobe and write data, plus the read data and the TX-full flag.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a,
    output mem_wr,
    output mem_dout,
    input  mem_din,
    input  io_buffer_full
  );

  modport slave (
    input  mem_a,
    input  mem_wr,
    input  mem_dout,
    output mem_din,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: 2^ADDR_WIDTH bytes of RAM with one-cycle
// read latency, plus an IO window at mem_a[17:16]==2'b11 holding the UART RX
// byte, the UART TX FIFO, a free-running cycle counter and the program-end flag.
module mem_io_responder #(
  parameter int ADDR_WIDTH   = 17,
  parameter int TX_DEPTH_BIT = 3,
  parameter int FULL_MARGIN  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  mem_io_responder_if.slave    bus,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 program_end,
  output logic                 tx_overflow
);

  localparam int                    DEPTH      = 1 << TX_DEPTH_BIT;
  localparam int                    CNT_W      = TX_DEPTH_BIT + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      FULL_LVL_C = CNT_W'(DEPTH - FULL_MARGIN);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [TX_DEPTH_BIT-1:0] PTR_ONE  = TX_DEPTH_BIT'(1);

  logic [7:0]              ram_r [2**ADDR_WIDTH];
  logic [7:0]              tx_buf_r [DEPTH];

  logic [7:0]              mem_din_r;
  logic [31:0]             cycle_cnt_r;
  logic [31:0]             snap_r;
  logic [TX_DEPTH_BIT-1:0] head_r;
  logic [TX_DEPTH_BIT-1:0] tail_r;
  logic [CNT_W-1:0]        count_r;
  logic                    program_end_r;
  logic                    tx_overflow_r;

  logic                    is_io_s;
  logic [2:0]              sel_s;
  logic [ADDR_WIDTH-1:0]   idx_s;
  logic [7:0]              io_rd_data_s;
  logic                    rx_take_s;
  logic                    push_s;
  logic [7:0]              push_data_s;
  logic                    end_set_s;
  logic                    snap_load_s;
  logic                    pop_s;
  logic                    accept_s;
  logic                    unused_addr_s;

  assign is_io_s       = (bus.mem_a[17:16] == 2'b11);
  assign sel_s         = bus.mem_a[2:0];
  assign idx_s         = bus.mem_a[ADDR_WIDTH-1:0];
  assign unused_addr_s = ^bus.mem_a[31:18];

  // IO window decode: read mux, RX handshake and TX push/program-end requests.
  always_comb begin
    io_rd_data_s = 8'h00;
    rx_take_s    = 1'b0;
    push_s       = 1'b0;
    push_data_s  = 8'h00;
    end_set_s    = 1'b0;
    snap_load_s  = 1'b0;
    if (!rst_in && is_io_s) begin
      if (bus.mem_wr) begin
        case (sel_s)
          3'd0: begin
            push_s      = (bus.mem_dout != 8'h00);
            push_data_s = bus.mem_dout;
          end
          3'd4: begin
            end_set_s   = 1'b1;
            push_s      = 1'b1;
            push_data_s = 8'h00;
          end
          default: push_s = 1'b0;
        endcase
      end else begin
        case (sel_s)
          3'd0: begin
            if (rx_valid) begin
              io_rd_data_s = rx_data;
              rx_take_s    = 1'b1;
            end else begin
              io_rd_data_s = 8'h00;
              rx_take_s    = 1'b0;
            end
          end
          3'd4: begin
            io_rd_data_s = cycle_cnt_r[7:0];
            snap_load_s  = 1'b1;
          end
          3'd5:    io_rd_data_s = snap_r[15:8];
          3'd6:    io_rd_data_s = snap_r[23:16];
          3'd7:    io_rd_data_s = snap_r[31:24];
          default: io_rd_data_s = 8'h00;
        endcase
      end
    end else begin
      io_rd_data_s = 8'h00;
      rx_take_s    = 1'b0;
    end
  end

  // A push still fits when the FIFO is full if the head leaves in the same cycle.
  assign pop_s    = (count_r != {CNT_W{1'b0}}) && tx_ready;
  assign accept_s = push_s && ((count_r < DEPTH_C) || pop_s);

  // RAM write port; storage is deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !is_io_s && bus.mem_wr) begin
      ram_r[idx_s] <= bus.mem_dout;
    end
  end

  // TX FIFO storage; only accepted pushes land at the tail.
  always_ff @(posedge clk_in) begin
    if (accept_s) begin
      tx_buf_r[tail_r] <= push_data_s;
    end
  end

  // Read data, counter/snapshot, FIFO pointers and sticky flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din_r     <= 8'h00;
      cycle_cnt_r   <= 32'd0;
      snap_r        <= 32'd0;
      head_r        <= {TX_DEPTH_BIT{1'b0}};
      tail_r        <= {TX_DEPTH_BIT{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      program_end_r <= 1'b0;
      tx_overflow_r <= 1'b0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
      if (!bus.mem_wr) begin
        mem_din_r <= is_io_s ? io_rd_data_s : ram_r[idx_s];
      end
      if (snap_load_s) begin
        snap_r <= cycle_cnt_r;
      end
      if (end_set_s) begin
        program_end_r <= 1'b1;
      end
      if (push_s && !accept_s) begin
        tx_overflow_r <= 1'b1;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (accept_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.mem_din        = mem_din_r;
  assign bus.io_buffer_full = (count_r >= FULL_LVL_C);
  assign rx_ready           = rx_take_s;
  assign tx_valid           = (count_r != {CNT_W{1'b0}});
  assign tx_data            = tx_buf_r[head_r];
  assign program_end        = program_end_r;
  assign tx_overflow        = tx_overflow_r;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_mem_io_responder;

  localparam int DEPTH    = 8;
  localparam int FULL_LVL = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_end;
  logic        tx_overflow;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .bus         (bus),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .program_end (program_end),
    .tx_overflow (tx_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model state. It starts in the post-reset state because the
  // bench holds rst high through the first clock edge.
  logic [7:0]  m_mem [int];
  logic [7:0]  m_din       = 8'h00;
  bit          m_din_known = 1'b1;
  logic [7:0]  m_q [$];
  bit          m_end       = 1'b0;
  bit          m_ovf       = 1'b0;
  logic [31:0] m_cyc       = 32'd0;
  logic [31:0] m_snap      = 32'd0;

  // Advance the model by one clock edge using the inputs that edge will sample.
  task automatic model_step();
    logic [31:0] a;
    logic [2:0]  sel;
    int          idx;
    bit          io;
    bit          push;
    logic [7:0]  pd;
    a    = bus.mem_a;
    sel  = a[2:0];
    idx  = int'(a[16:0]);
    io   = (a[17:16] == 2'b11);
    push = 1'b0;
    pd   = 8'h00;
    if (rst) begin
      m_din = 8'h00; m_din_known = 1'b1; m_q.delete();
      m_end = 1'b0; m_ovf = 1'b0; m_cyc = 32'd0; m_snap = 32'd0;
    end else begin
      if (!io) begin
        if (bus.mem_wr) m_mem[idx] = bus.mem_dout;
        else if (m_mem.exists(idx)) begin m_din = m_mem[idx]; m_din_known = 1'b1; end
        else m_din_known = 1'b0;
      end else if (!bus.mem_wr) begin
        m_din_known = 1'b1;
        if (sel == 3'd0)      m_din = rx_valid ? rx_data : 8'h00;
        else if (sel == 3'd4) begin m_din = m_cyc[7:0]; m_snap = m_cyc; end
        else if (sel >= 3'd5) m_din = m_snap[8*(sel-3'd4) +: 8];
        else                  m_din = 8'h00;
      end else begin
        if (sel == 3'd0 && bus.mem_dout != 8'h00) begin push = 1'b1; pd = bus.mem_dout; end
        if (sel == 3'd4) begin m_end = 1'b1; push = 1'b1; pd = 8'h00; end
      end
      if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(pd);
        else m_ovf = 1'b1;
      end
      m_cyc = m_cyc + 32'd1;
    end
  endtask

  // Compare every output against the model mid-cycle, then advance the model.
  logic exp_rx;
  always @(negedge clk) begin
    check("tx_valid", tx_valid, (m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
    check("io_buffer_full", bus.io_buffer_full, (m_q.size() >= FULL_LVL));
    check("program_end", program_end, m_end);
    check("tx_overflow", tx_overflow, m_ovf);
    if (m_din_known) check("mem_din", bus.mem_din, m_din);
    exp_rx = !rst && !bus.mem_wr && (bus.mem_a[17:16] == 2'b11) &&
             (bus.mem_a[2:0] == 3'd0) && rx_valid;
    check("rx_ready", rx_ready, exp_rx);
    model_step();
  end

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_wr   = wr;
    bus.mem_dout = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0]  b0, b1, b2, b3;
  logic [16:0] pool [16];
  logic [31:0] tmp;
  int          n;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    drive(32'h0, 1'b0, 8'h00);
    tick();
    check("reset mem_din", bus.mem_din, 8'h00);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset full", bus.io_buffer_full, 1'b0);
    check("reset program_end", program_end, 1'b0);
    check("reset overflow", tx_overflow, 1'b0);
    rst = 1'b0;

    // RAM write, read, alias and hold-on-write
    drive(32'h0001_0, 1'b1, 8'hA5); tick();
    drive(32'h0001_0, 1'b0, 8'h00); tick();
    check("ram read", bus.mem_din, 8'hA5);
    drive(32'h0002_0010, 1'b0, 8'h00); tick();
    check("ram alias", bus.mem_din, 8'hA5);
    drive(32'h0000_0011, 1'b1, 8'h5A); tick();
    check("din hold on write", bus.mem_din, 8'hA5);

    // TX with consumer ready; the 0x00 write is never emitted
    tx_ready = 1'b1;
    drive(32'h0003_0000, 1'b1, 8'h48); tick();
    check("tx H valid", tx_valid, 1'b1);
    check("tx H data", tx_data, 8'h48);
    drive(32'h0003_0000, 1'b1, 8'h00); tick();
    check("tx zero ignored", tx_valid, 1'b0);
    drive(32'h0003_0000, 1'b1, 8'h69); tick();
    check("tx i data", tx_data, 8'h69);
    drive(32'h0003_0001, 1'b0, 8'h00); tick();
    check("tx drained", tx_valid, 1'b0);

    // Fill to full, overflow, then push+pop at full
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(32'h0003_0000, 1'b1, 8'(i)); tick();
      if (i == 5) check("full after 5", bus.io_buffer_full, 1'b0);
      if (i == 6) check("full after 6", bus.io_buffer_full, 1'b1);
      if (i == 8) check("no overflow at 8", tx_overflow, 1'b0);
      if (i == 9) check("overflow at 9", tx_overflow, 1'b1);
    end
    check("head after overflow", tx_data, 8'h01);
    tx_ready = 1'b1;
    drive(32'h0003_0000, 1'b1, 8'h0A); tick();
    check("push+pop at full head", tx_data, 8'h02);
    check("push+pop at full still full", bus.io_buffer_full, 1'b1);
    drive(32'h0003_0001, 1'b0, 8'h00);
    n = 0;
    while (tx_valid && n < 20) begin tick(); n++; end
    check("drain count stays 8", n, 8);

    // RX byte read and empty read
    rx_valid = 1'b1; rx_data = 8'h37;
    drive(32'h0003_0000, 1'b0, 8'h00); #1;
    check("rx_ready set", rx_ready, 1'b1);
    tick();
    check("rx data", bus.mem_din, 8'h37);
    rx_valid = 1'b0; #1;
    check("rx_ready clear", rx_ready, 1'b0);
    tick();
    check("rx empty data", bus.mem_din, 8'h00);

    // Cycle counter snapshot 100 edges after reset
    rst = 1'b1; drive(32'h0003_0001, 1'b0, 8'h00); tick();
    rst = 1'b0;
    repeat (100) tick();
    drive(32'h0003_0004, 1'b0, 8'h00); tick(); b0 = bus.mem_din;
    drive(32'h0003_0005, 1'b0, 8'h00); tick(); b1 = bus.mem_din;
    drive(32'h0003_0006, 1'b0, 8'h00); tick(); b2 = bus.mem_din;
    repeat (5) tick();
    drive(32'h0003_0007, 1'b0, 8'h00); tick(); b3 = bus.mem_din;
    check("snapshot", {b3, b2, b1, b0}, 32'd100);

    // Program end, stickiness, and reset clearing it
    tx_ready = 1'b0;
    drive(32'h0003_0004, 1'b1, 8'hFF); tick();
    check("program_end set", program_end, 1'b1);
    check("end byte valid", tx_valid, 1'b1);
    check("end byte data", tx_data, 8'h00);
    drive(32'h0003_0001, 1'b0, 8'h00); tick();
    check("program_end sticky", program_end, 1'b1);
    rst = 1'b1; tx_ready = 1'b1; tick();
    check("rst program_end", program_end, 1'b0);
    check("rst fifo empty", tx_valid, 1'b0);
    check("rst mem_din", bus.mem_din, 8'h00);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) begin
      tmp = $urandom;
      pool[i] = tmp[16:0];
    end
    pool[0] = 17'h00010;
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      tx_ready = ($urandom_range(0, 2) != 0);
      rx_valid = $urandom_range(0, 1);
      rx_data  = 8'($urandom);
      tmp      = $urandom;
      if ($urandom_range(0, 9) < 5) begin
        tmp[16:0] = pool[$urandom_range(0, 15)];
        if (tmp[17:16] == 2'b11) tmp[17] = 1'b0;
        drive(tmp, 1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        tmp[17:16] = 2'b11;
        tmp[15:3]  = 13'd0;
        tmp[2:0]   = 3'($urandom_range(0, 7));
        if (tmp[2:0] == 3'd4 && $urandom_range(0, 3) != 0) tmp[2:0] = 3'd0;
        drive(tmp, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end
      tick();
    end
    rst = 1'b0;
    drive(32'h0003_0001, 1'b0, 8'h00);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
